decypher: RTL and testbench

Inverse of the one-time-pad cypher path: recovers a `MSG_SIZE`-bit plaintext from a `MSG_SIZE`-bit ciphertext and a stream of `KEY_SIZE`-bit key blocks. It XORs one key block per accepted key beat, most-significant block first. Key blocks must arrive in the same order the cypher consumed them. It sits on the receive side of the link, downstream of the ciphertext register and fed by the same key source as the cypher, with a start/busy/done control handshake.

---
 rtl/decypher.sv | 100 ++++++++++
 tb/tb_decypher.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/decypher.sv
// decypher: recovers a MSG_SIZE-bit plaintext from a ciphertext and a stream
// of KEY_SIZE-bit key blocks, XORing one block per accepted key beat,
// most-significant block first. Start/busy/done control handshake.
module decypher #(
    parameter int MSG_SIZE = 32,
    parameter int KEY_SIZE = 8
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                start_i,
    input  logic [MSG_SIZE-1:0] cipher_i,
    input  logic                key_valid_i,
    input  logic [KEY_SIZE-1:0] key_i,
    output logic                key_ready_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [MSG_SIZE-1:0] plain_o
);

    localparam int N     = MSG_SIZE / KEY_SIZE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(N - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [MSG_SIZE-1:0] shreg_q, shreg_d;
    logic [MSG_SIZE-1:0] acc_q,   acc_d;
    logic [MSG_SIZE-1:0] plain_q, plain_d;
    logic                done_q,  done_d;

    logic                beat;
    logic [KEY_SIZE-1:0] blk;
    logic [MSG_SIZE-1:0] acc_shift;

    // Handshake outputs come straight from the state register so that
    // key_ready never combinationally depends on key_valid.
    assign busy_o      = (state_q == S_RUN);
    assign key_ready_o = (state_q == S_RUN);
    assign done_o      = done_q;
    assign plain_o     = plain_q;

    assign beat      = key_valid_i && key_ready_o;
    assign blk       = shreg_q[MSG_SIZE-1 -: KEY_SIZE] ^ key_i;
    assign acc_shift = {acc_q[MSG_SIZE-KEY_SIZE-1:0], blk};

    // Next-state logic: load on start in IDLE, consume one block per beat in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        acc_d   = acc_q;
        plain_d = plain_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    shreg_d = cipher_i;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = S_RUN;
                end
            end
            default: begin
                if (beat) begin
                    shreg_d = shreg_q << KEY_SIZE;
                    acc_d   = acc_shift;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_BLK) begin
                        plain_d = acc_shift;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
        endcase
    end

    // State registers with synchronous active-low reset taking priority.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            acc_q   <= '0;
            plain_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            plain_q <= plain_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_decypher.sv
// tb_decypher: directed and randomized checks of decypher against a
// plaintext = ciphertext XOR concatenated-keys reference model.
module tb_decypher;

    localparam int MS = 32;
    localparam int KS = 8;
    localparam int N  = MS / KS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [MS-1:0] cipher = '0;
    logic          key_valid = 1'b0;
    logic [KS-1:0] key = '0;
    logic          key_ready;
    logic          busy;
    logic          done;
    logic [MS-1:0] plain;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [MS-1:0] model_plain = '0;

    always #5 clk = ~clk;

    decypher #(.MSG_SIZE(MS), .KEY_SIZE(KS)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .start_i     (start),
        .cipher_i    (cipher),
        .key_valid_i (key_valid),
        .key_i       (key),
        .key_ready_o (key_ready),
        .busy_o      (busy),
        .done_o      (done),
        .plain_o     (plain)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Idle cycles with junk on the key bus: nothing may be consumed.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            start     = 1'b0;
            key_valid = 1'($urandom_range(0, 1));
            key       = KS'($urandom);
            cipher    = $urandom;
            step;
            chk("idle_done",  {31'b0, done},      32'd0);
            chk("idle_busy",  {31'b0, busy},      32'd0);
            chk("idle_ready", {31'b0, key_ready}, 32'd0);
            chk("idle_plain", plain, model_plain);
        end
        key_valid = 1'b0;
    endtask

    // One message: start, then N key beats with an optional gap before
    // beat gap_at, and an optional ignored start alongside beat inj.
    task automatic run_msg(input logic [MS-1:0] c, input logic [MS-1:0] keys,
                           input int gap_at, input int gap_len, input int inj);
        int            lat;
        logic [MS-1:0] exp;
        exp       = c ^ keys;
        start     = 1'b1;
        cipher    = c;
        key_valid = 1'($urandom_range(0, 1));
        key       = KS'($urandom);
        step;
        lat    = 1;
        start  = 1'b0;
        cipher = $urandom;
        for (int i = 0; i < N; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    key_valid = 1'b0;
                    key       = KS'($urandom);
                    chk("gap_ready", {31'b0, key_ready}, 32'd1);
                    chk("gap_done",  {31'b0, done},      32'd0);
                    chk("gap_plain", plain, model_plain);
                    step;
                    lat++;
                end
            end
            key_valid = 1'b1;
            key       = keys[MS-1-KS*i -: KS];
            if (i == inj) begin
                start  = 1'b1;
                cipher = 32'hFFFF_FFFF;
            end
            chk("run_busy",  {31'b0, busy},      32'd1);
            chk("run_ready", {31'b0, key_ready}, 32'd1);
            chk("run_done",  {31'b0, done},      32'd0);
            chk("run_plain", plain, model_plain);
            step;
            lat++;
            start = 1'b0;
        end
        key_valid = 1'b0;
        chk("done",     {31'b0, done}, 32'd1);
        chk("plain",    plain, exp);
        chk("end_busy", {31'b0, busy}, 32'd0);
        chk("latency",  lat, 1 + N + gap_len);
        model_plain = exp;
    endtask

    initial begin
        // Reset with random inputs.
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start     = 1'($urandom_range(0, 1));
            cipher    = $urandom;
            key_valid = 1'($urandom_range(0, 1));
            key       = KS'($urandom);
            step;
        end
        chk("rst_busy",  {31'b0, busy},      32'd0);
        chk("rst_ready", {31'b0, key_ready}, 32'd0);
        chk("rst_done",  {31'b0, done},      32'd0);
        chk("rst_plain", plain, 32'h0);
        rst_n = 1'b1;
        idle(2);

        // Basic decrypt.
        run_msg(32'hDEAD_BEEF, 32'h1122_3344, -1, 0, -1);
        chk("basic_val", model_plain, 32'hCF8F_8DAB);
        idle(2);

        // Round trip of the cypher output for 0x12345678.
        run_msg(32'hB76E_A978, 32'hA55A_FF00, -1, 0, -1);
        chk("rtrip_val", plain, 32'h1234_5678);
        idle(1);

        // Key stall of 3 cycles between 2nd and 3rd keys.
        run_msg(32'hDEAD_BEEF, 32'h1122_3344, 2, 3, -1);
        idle(1);

        // Start while busy is ignored.
        run_msg(32'hDEAD_BEEF, 32'h1122_3344, -1, 0, 2);
        idle(1);

        // Reset after 2 beats discards the message.
        start = 1'b1; cipher = 32'hDEAD_BEEF;
        step;
        start = 1'b0; key_valid = 1'b1; key = 8'h11;
        step;
        key = 8'h22;
        step;
        rst_n = 1'b0; key = 8'h33; start = 1'b1;
        step;
        rst_n = 1'b1; key_valid = 1'b0; start = 1'b0;
        chk("mrst_busy",  {31'b0, busy},      32'd0);
        chk("mrst_ready", {31'b0, key_ready}, 32'd0);
        chk("mrst_done",  {31'b0, done},      32'd0);
        chk("mrst_plain", plain, 32'h0);
        model_plain = '0;
        idle(3);

        // Basic after reset, then back-to-back start in the done cycle.
        run_msg(32'hDEAD_BEEF, 32'h1122_3344, -1, 0, -1);
        run_msg(32'h0000_0000, 32'h0102_0304, -1, 0, -1);
        chk("b2b_val", plain, 32'h0102_0304);
        idle(2);

        // Randomized messages, gaps and inter-message spacing.
        for (int m = 0; m < 40; m++) begin
            int ga, gl;
            ga = $urandom_range(0, N - 1);
            gl = $urandom_range(0, 3);
            run_msg($urandom, $urandom, ga, gl, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1);
            idle($urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
